// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pkg
// Brief   : Shared types, constants and helpers for the MEM pipeline stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_data_width     = 32;
    localparam int c_reg_addr_width = 5;

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;
    localparam logic [1:0] c_size_rsvd = 2'b11;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Widen a byte (is_half=0) or halfword (is_half=1) to a full word.
    function automatic logic [c_data_width-1:0] extend_load(
        input logic [15:0] val,
        input logic        is_half,
        input logic        zero_ext
    );
        logic [c_data_width-1:0] res;
        if (is_half) begin
            res = zero_ext ? {16'h0000, val} : {{16{val[15]}}, val};
        end else begin
            res = zero_ext ? {24'h000000, val[7:0]} : {{24{val[7]}}, val[7:0]};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module  : load_store_align
// Brief   : Byte-lane steering for stores, lane select/extension for loads,
//           and misalignment detection.
// Revision: 1.0 - initial release
// ============================================================================
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]              off,
    input  logic [1:0]              mem_size,
    input  logic                    mem_unsigned,
    input  logic                    access,
    input  logic [c_data_width-1:0] store_data_in,
    input  logic [c_data_width-1:0] mem_word,
    output logic [3:0]              byte_en,
    output logic [c_data_width-1:0] store_data,
    output logic [c_data_width-1:0] load_data,
    output logic                    misaligned
);

    logic                    w_is_byte;
    logic                    w_is_half;
    logic [c_data_width-1:0] w_shifted;
    logic [15:0]             w_half_sel;

    always_comb begin
        w_is_byte = 1'b0;
        w_is_half = 1'b0;
        unique case (mem_size)
            c_size_byte: w_is_byte = 1'b1;
            c_size_half: w_is_half = 1'b1;
            c_size_word, c_size_rsvd: ;
        endcase
    end

    assign misaligned = access & ((w_is_half & off[0]) |
                                  (~w_is_byte & ~w_is_half & (off != 2'b00)));

    // Replicating the data across lanes lets byte_en alone pick the target.
    always_comb begin
        byte_en    = 4'b1111;
        store_data = store_data_in;
        if (w_is_byte) begin
            byte_en    = 4'b0001 << off;
            store_data = {4{store_data_in[7:0]}};
        end else if (w_is_half) begin
            byte_en    = off[1] ? 4'b1100 : 4'b0011;
            store_data = {2{store_data_in[15:0]}};
        end
    end

    assign w_shifted  = mem_word >> {off, 3'b000};
    assign w_half_sel = off[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = mem_word;
        if (w_is_byte) begin
            load_data = extend_load({8'h00, w_shifted[7:0]}, 1'b0, mem_unsigned);
        end else if (w_is_half) begin
            load_data = extend_load(w_half_sel, 1'b1, mem_unsigned);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage
// Brief   : MIPS MEM stage - data memory, zero-fill sweep after reset,
//           aligned byte/half/word access and a registered debug read port.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int MEM_WORDS  = 256,
    parameter int ADDR_W     = $clog2(MEM_WORDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       alu_result_in,
    input  logic [DATA_WIDTH-1:0]       write_data_in,
    input  logic                        mem_read_in,
    input  logic                        mem_write_in,
    input  logic [1:0]                  mem_size_in,
    input  logic                        mem_unsigned_in,
    input  logic [c_reg_addr_width-1:0] write_register_in,
    input  logic                        reg_write_in,
    input  logic                        mem_to_reg_in,
    input  logic [DATA_WIDTH-1:0]       pc_plus_4_in,
    input  logic                        is_jal_in,
    output logic [DATA_WIDTH-1:0]       alu_result_out,
    output logic [DATA_WIDTH-1:0]       read_data_out,
    output logic [c_reg_addr_width-1:0] write_register_out,
    output logic                        reg_write_out,
    output logic                        mem_to_reg_out,
    output logic [DATA_WIDTH-1:0]       pc_plus_4_out,
    output logic                        is_jal_out,
    output logic                        misaligned_out,
    output logic                        busy_out,
    input  logic                        dbg_req_in,
    input  logic [ADDR_W-1:0]           dbg_addr_in,
    output logic [DATA_WIDTH-1:0]       dbg_data_out,
    output logic                        dbg_valid_out
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_clr_ptr;
    logic                  w_run;

    logic [ADDR_W-1:0]     w_word;
    logic [DATA_WIDTH-1:0] w_rword;
    logic [3:0]            w_byte_en;
    logic [DATA_WIDTH-1:0] w_store_data;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_misaligned;
    logic                  w_store_en;
    logic                  w_unused_addr;

    // Upper address bits wrap modulo the memory size.
    assign w_word        = alu_result_in[ADDR_W+1:2];
    assign w_unused_addr = ^alu_result_in[DATA_WIDTH-1:ADDR_W+2];
    assign w_rword       = r_mem[w_word];

    load_store_align u_align (
        .off           (alu_result_in[1:0]),
        .mem_size      (mem_size_in),
        .mem_unsigned  (mem_unsigned_in),
        .access        (mem_read_in | mem_write_in),
        .store_data_in (write_data_in),
        .mem_word      (w_rword),
        .byte_en       (w_byte_en),
        .store_data    (w_store_data),
        .load_data     (w_load_data),
        .misaligned    (w_misaligned)
    );

    // Sweep FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_out    = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                busy_out = 1'b1;
                if (r_clr_ptr == ADDR_W'(MEM_WORDS - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: ;
        endcase
    end

    assign w_run      = (r_state == ST_RUN);
    assign w_store_en = w_run & mem_write_in & ~w_misaligned;

    // Storage has no reset; the sweep provides the zero state.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b]) begin
                    r_mem[w_word][8*b +: 8] <= w_store_data[8*b +: 8];
                end
            end
        end
    end

    // Debug read samples the array before any same-edge store lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_data_out  <= '0;
            dbg_valid_out <= 1'b0;
        end else if (w_run && dbg_req_in) begin
            dbg_data_out  <= r_mem[dbg_addr_in];
            dbg_valid_out <= 1'b1;
        end else begin
            dbg_valid_out <= 1'b0;
        end
    end

    assign read_data_out  = (w_run && mem_read_in && !w_misaligned) ? w_load_data : '0;
    assign misaligned_out = w_misaligned;
    assign reg_write_out  = reg_write_in & ~(mem_read_in & w_misaligned);

    assign alu_result_out     = alu_result_in;
    assign write_register_out = write_register_in;
    assign mem_to_reg_out     = mem_to_reg_in;
    assign pc_plus_4_out      = pc_plus_4_in;
    assign is_jal_out         = is_jal_in;

endmodule
`default_nettype wire
